// File: rtl/clock_divider_multi.sv
// clock_divider_multi: multi-channel programmable clock divider.
// Each channel divides clock_in by its active divisor. The output is high
// for the first `high` cycles of every period. A one-cycle tick marks the
// start of each period. New div/high values load through a valid/ready
// port into a shadow copy. They become active only at a period boundary,
// or at once while the channel is disabled.
// Optional build macro CLKDIV_PHASE_ALIGN_EN adds a `sync` input. A sync
// strobe restarts every enabled channel together and applies any pending
// updates in that cycle.
module clock_divider_multi #(
   parameter int CHANNELS     = 4,
   parameter int CNT_W        = 28,
   parameter int DEFAULT_DIV  = 4,
   parameter int DEFAULT_HIGH = 1,
   localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clock_in,
   input  logic                rst,
`ifdef CLKDIV_PHASE_ALIGN_EN
   input  logic                sync,
`endif
   input  logic [CHANNELS-1:0] en,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CH_W-1:0]     cfg_ch,
   input  logic [CNT_W-1:0]    cfg_div,
   input  logic [CNT_W-1:0]    cfg_high,
   output logic [CHANNELS-1:0] clock_out,
   output logic [CHANNELS-1:0] tick
);

   localparam logic [CNT_W-1:0] DEF_DIV  = CNT_W'(DEFAULT_DIV);
   localparam logic [CNT_W-1:0] DEF_HIGH = CNT_W'(DEFAULT_HIGH);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   logic [CNT_W-1:0]    div_q   [CHANNELS];
   logic [CNT_W-1:0]    high_q  [CHANNELS];
   logic [CNT_W-1:0]    div_s   [CHANNELS];
   logic [CNT_W-1:0]    high_s  [CHANNELS];
   logic [CNT_W-1:0]    cnt     [CHANNELS];
   logic [CNT_W-1:0]    div_eff [CHANNELS];
   logic [CHANNELS-1:0] pend;
   logic [CHANNELS-1:0] last;
   logic                in_range;
   logic                accept;
   logic                sync_int;

`ifdef CLKDIV_PHASE_ALIGN_EN
   assign sync_int = sync;
`else
   assign sync_int = 1'b0;
`endif

   // Handshake: ready depends only on pend and cfg_ch, never on cfg_valid.
   // Channels that do not exist are always ready, and their writes are dropped.
   always_comb begin
      in_range  = (32'(cfg_ch) < CHANNELS);
      cfg_ready = 1'b1;
      if (in_range) begin
         cfg_ready = !pend[cfg_ch];
      end
      accept = cfg_valid && cfg_ready;
   end

   // A divisor of 0 behaves as 1. `last` flags the wrap cycle of the period.
   always_comb begin
      for (int c = 0; c < CHANNELS; c++) begin
         div_eff[c] = (div_q[c] == '0) ? ONE : div_q[c];
         last[c]    = (cnt[c] == (div_eff[c] - ONE));
      end
   end

   // Per-channel counter, registered outputs, and shadow-to-active transfer.
   always_ff @(posedge clock_in) begin
      if (rst) begin
         for (int c = 0; c < CHANNELS; c++) begin
            cnt[c]    <= '0;
            div_q[c]  <= DEF_DIV;
            high_q[c] <= DEF_HIGH;
            div_s[c]  <= DEF_DIV;
            high_s[c] <= DEF_HIGH;
         end
         pend      <= '0;
         clock_out <= '0;
         tick      <= '0;
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (!en[c]) begin
               cnt[c]       <= '0;
               clock_out[c] <= 1'b0;
               tick[c]      <= 1'b0;
               if (pend[c]) begin
                  div_q[c]  <= div_s[c];
                  high_q[c] <= high_s[c];
                  pend[c]   <= 1'b0;
               end
            end else begin
               clock_out[c] <= (cnt[c] < high_q[c]);
               tick[c]      <= (cnt[c] == '0);
               // sync takes priority over the wrap. Both restart the period.
               if (sync_int || last[c]) begin
                  cnt[c] <= '0;
                  if (pend[c]) begin
                     div_q[c]  <= div_s[c];
                     high_q[c] <= high_s[c];
                     pend[c]   <= 1'b0;
                  end
               end else begin
                  cnt[c] <= cnt[c] + ONE;
               end
            end
            // An accept needs pend clear, so it never overlaps an apply.
            if (accept && in_range && (CH_W'(c) == cfg_ch)) begin
               div_s[c]  <= cfg_div;
               high_s[c] <= cfg_high;
               pend[c]   <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Bench for clock_divider_multi. A period-template reference model feeds
// expected outputs and ready values into queues. Independent monitors pop
// those queues and compare them against the DUT.
// A second, 3-channel instance covers writes to a channel that does not exist.
module tb_clock_divider_multi;

   localparam int CH = 4;
   localparam int W  = 28;

   logic          clock_in = 1'b0;
   logic          rst;
   logic          sync;
   logic [CH-1:0] en;
   logic          cfg_valid;
   logic          cfg_ready;
   logic [1:0]    cfg_ch;
   logic [W-1:0]  cfg_div;
   logic [W-1:0]  cfg_high;
   logic [CH-1:0] clock_out;
   logic [CH-1:0] tick;

   logic [2:0]    en3;
   logic          cfg_valid3;
   logic          cfg_ready3;
   logic [1:0]    cfg_ch3;
   logic [2:0]    clock_out3;
   logic [2:0]    tick3;

   int checks   = 0;
   int failures = 0;

   logic [7:0] q_out[$];
   bit         q_rdy[$];

   clock_divider_multi u_dut (
      .clock_in (clock_in),
      .rst      (rst),
`ifdef CLKDIV_PHASE_ALIGN_EN
      .sync     (sync),
`endif
      .en       (en),
      .cfg_valid(cfg_valid),
      .cfg_ready(cfg_ready),
      .cfg_ch   (cfg_ch),
      .cfg_div  (cfg_div),
      .cfg_high (cfg_high),
      .clock_out(clock_out),
      .tick     (tick)
   );

   clock_divider_multi #(.CHANNELS(3)) u_dut3 (
      .clock_in (clock_in),
      .rst      (rst),
`ifdef CLKDIV_PHASE_ALIGN_EN
      .sync     (sync),
`endif
      .en       (en3),
      .cfg_valid(cfg_valid3),
      .cfg_ready(cfg_ready3),
      .cfg_ch   (cfg_ch3),
      .cfg_div  (cfg_div),
      .cfg_high (cfg_high),
      .clock_out(clock_out3),
      .tick     (tick3)
   );

   always #5 clock_in = ~clock_in;

   // Reference model. Each period is expanded into a waveform of div entries
   // of {clock, tick}. The channel plays back one entry per enabled cycle.
   // An emptied waveform marks the period boundary.
   int       m_div    [CH];
   int       m_high   [CH];
   int       m_div_s  [CH];
   int       m_high_s [CH];
   bit       m_pend   [CH];
   bit [1:0] m_wave   [CH][$];

   task automatic model_apply(input int c);
      m_div[c]  = m_div_s[c];
      m_high[c] = m_high_s[c];
      m_pend[c] = 1'b0;
   endtask

   task automatic model_step();
      logic [CH-1:0] eo;
      logic [CH-1:0] et;
      bit            r;
      bit [1:0]      w;
      int            d;
      eo = '0;
      et = '0;
      r  = !m_pend[cfg_ch];
      if (!rst) q_rdy.push_back(r);
      for (int c = 0; c < CH; c++) begin
         if (rst) begin
            m_div[c] = 4; m_high[c] = 1; m_div_s[c] = 4; m_high_s[c] = 1;
            m_pend[c] = 1'b0;
            m_wave[c].delete();
         end else begin
            if (!en[c]) begin
               m_wave[c].delete();
               if (m_pend[c]) model_apply(c);
            end else begin
               if (m_wave[c].size() == 0) begin
                  d = (m_div[c] == 0) ? 1 : m_div[c];
                  for (int i = 0; i < d; i++) m_wave[c].push_back({i < m_high[c], i == 0});
               end
               w = m_wave[c].pop_front();
               eo[c] = w[1];
               et[c] = w[0];
`ifdef CLKDIV_PHASE_ALIGN_EN
               if (sync) m_wave[c].delete();
`endif
               if (m_wave[c].size() == 0 && m_pend[c]) model_apply(c);
            end
            if (cfg_valid && r && (int'(cfg_ch) == c)) begin
               m_div_s[c]  = int'(cfg_div);
               m_high_s[c] = int'(cfg_high);
               m_pend[c]   = 1'b1;
            end
         end
      end
      q_out.push_back({eo, et});
   endtask

   task automatic step();
      model_step();
      @(negedge clock_in);
   endtask

   task automatic chk(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
      end
   endtask

   // Output monitor: registered outputs just after each active edge.
   initial begin
      logic [7:0] e;
      forever begin
         @(posedge clock_in);
         #1;
         if (q_out.size() > 0) begin
            e = q_out.pop_front();
            checks++;
            if ({clock_out, tick} !== e) begin
               failures++;
               $display("FAIL outputs: got clock_out=%b tick=%b expected clock_out=%b tick=%b at %0t",
                        clock_out, tick, e[7:4], e[3:0], $time);
            end
         end
      end
   end

   // Ready monitor: cfg_ready sampled mid-cycle once inputs have settled.
   initial begin
      bit r;
      forever begin
         @(negedge clock_in);
         #2;
         if (q_rdy.size() > 0) begin
            r = q_rdy.pop_front();
            checks++;
            if (cfg_ready !== r) begin
               failures++;
               $display("FAIL cfg_ready: got %b expected %b (ch %0d) at %0t", cfg_ready, r, cfg_ch, $time);
            end
         end
      end
   end

   initial begin
      rst = 1'b1; sync = 1'b0; en = '0; cfg_valid = 1'b0; cfg_ch = '0;
      cfg_div = '0; cfg_high = '0;
      en3 = '0; cfg_valid3 = 1'b0; cfg_ch3 = '0;
      step(); step();
      rst = 1'b0;

      // defaults on channel 0
      en = 4'b0001;
      repeat (13) step();

      // reprogram channel 0 mid-period
      cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 6; cfg_high = 3;
      step();
      cfg_valid = 1'b0;
      repeat (16) step();

      // edge values
      cfg_valid = 1'b1;
      cfg_ch = 2'd1; cfg_div = 0; cfg_high = 1; step();
      cfg_ch = 2'd2; cfg_div = 1; cfg_high = 1; step();
      cfg_ch = 2'd3; cfg_div = 5; cfg_high = 9; step();
      cfg_ch = 2'd0; cfg_div = 3; cfg_high = 0; step();
      cfg_valid = 1'b0;
      repeat (4) step();
      en = 4'b1111;
      repeat (14) step();

      // disable with a pending update on channel 2
      cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 7; cfg_high = 3; step();
      cfg_valid = 1'b0;
      repeat (10) step();
      cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 3; cfg_high = 2; step();
      cfg_valid = 1'b0;
      step();
      en[2] = 1'b0;
      repeat (3) step();
      en[2] = 1'b1;
      repeat (8) step();

      // mid-operation reset with a custom channel 1 config
      cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 5; cfg_high = 2; step();
      cfg_valid = 1'b0;
      repeat (8) step();
      rst = 1'b1; step();
      rst = 1'b0;
      repeat (10) step();

      // writes to a channel that does not exist on the 3-channel instance
      en3 = 3'b111;
      cfg_valid3 = 1'b1; cfg_ch3 = 2'd3;
      #1 chk("oor_ready", cfg_ready3, 1'b1);
      step();
      #1 chk("oor_ready_again", cfg_ready3, 1'b1);
      step();
      cfg_valid3 = 1'b0;
      for (int c = 0; c < 3; c++) begin
         cfg_ch3 = 2'(c);
         #1 chk("oor_no_pend", cfg_ready3, 1'b1);
         step();
      end

`ifdef CLKDIV_PHASE_ALIGN_EN
      cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 3; cfg_high = 1; step();
      cfg_ch = 2'd1; cfg_div = 5; cfg_high = 2; step();
      cfg_valid = 1'b0;
      en = 4'b0011;
      repeat (7) step();
      sync = 1'b1; step();
      sync = 1'b0;
      repeat (10) step();
`endif

      // randomized traffic
      repeat (1500) begin
         rst = ($urandom_range(0, 199) == 0);
         for (int c = 0; c < CH; c++) if ($urandom_range(0, 99) < 3) en[c] = ~en[c];
         cfg_valid = ($urandom_range(0, 2) == 0);
         cfg_ch    = 2'($urandom_range(0, 3));
         cfg_div   = W'($urandom_range(0, 8));
         cfg_high  = W'($urandom_range(0, 9));
`ifdef CLKDIV_PHASE_ALIGN_EN
         sync = ($urandom_range(0, 49) == 0);
`endif
         step();
      end
      rst = 1'b0; cfg_valid = 1'b0; sync = 1'b0;
      step();
      @(posedge clock_in);
      #3;
      checks++;
      if (q_out.size() != 0) begin
         failures++;
         $display("FAIL drain: got %0d pending output entries expected 0", q_out.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
